// File: rtl/nic_buffered.sv
// Buffered network interface: a DEPTH-entry FIFO on each of the router input and output
// channels, plus a processor register window for data and status access.
module nic_buffered #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicEnWr,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Packet bit 0 is the MSB, i.e. vector bit DATA_W-1; packet bit DATA_W-1 is vector bit 0.
    localparam int unsigned PKT_BIT0 = DATA_W - 1;

    logic [DATA_W-1:0] in_mem_q  [DEPTH];
    logic [DATA_W-1:0] out_mem_q [DEPTH];

    logic [AW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic          drop_q, drop_d;

    logic rd_c, wr_c;
    logic in_full_c, in_empty_c, out_full_c, out_empty_c;
    logic in_push_c, in_pop_c, out_push_c, out_pop_c, drop_c;
    logic [DATA_W-1:0] in_head_c, out_head_c;
    logic [DATA_W-1:0] in_status_c, out_status_c;

    // Access decode, FIFO control and all combinational outputs.
    always_comb begin
        rd_c        = nicEn & ~nicEnWr;
        wr_c        = nicEn & nicEnWr;
        in_full_c   = (in_cnt_q == CW'(DEPTH));
        in_empty_c  = (in_cnt_q == '0);
        out_full_c  = (out_cnt_q == CW'(DEPTH));
        out_empty_c = (out_cnt_q == '0);
        in_head_c   = in_mem_q[in_rp_q];
        out_head_c  = out_mem_q[out_rp_q];

        net_ri     = ~in_full_c;
        in_push_c  = net_si & ~in_full_c;
        in_pop_c   = rd_c & (addr == 2'b00) & ~in_empty_c;
        out_push_c = wr_c & (addr == 2'b10) & ~out_full_c;
        drop_c     = wr_c & (addr == 2'b10) & out_full_c;
        net_so     = ~out_empty_c & net_ro & (out_head_c[PKT_BIT0] == net_polarity);
        out_pop_c  = net_so;
        net_do     = out_empty_c ? '0 : out_head_c;

        in_status_c                 = '0;
        in_status_c[DATA_W-1 -: 32] = 32'(in_cnt_q);
        in_status_c[0]              = ~in_empty_c;
        out_status_c                 = '0;
        out_status_c[DATA_W-1 -: 32] = 32'(out_cnt_q);
        out_status_c[0]              = out_full_c;
        out_status_c[1]              = drop_q;

        d_out = '0;
        if (rd_c) begin
            case (addr)
                2'b00:   d_out = in_empty_c ? '0 : in_head_c;
                2'b01:   d_out = in_status_c;
                2'b11:   d_out = out_status_c;
                default: d_out = '0;
            endcase
        end

        in_wp_d  = in_push_c  ? in_wp_q  + AW'(1) : in_wp_q;
        in_rp_d  = in_pop_c   ? in_rp_q  + AW'(1) : in_rp_q;
        out_wp_d = out_push_c ? out_wp_q + AW'(1) : out_wp_q;
        out_rp_d = out_pop_c  ? out_rp_q + AW'(1) : out_rp_q;

        in_cnt_d = in_cnt_q;
        if (in_push_c && !in_pop_c)      in_cnt_d = in_cnt_q + CW'(1);
        else if (!in_push_c && in_pop_c) in_cnt_d = in_cnt_q - CW'(1);

        out_cnt_d = out_cnt_q;
        if (out_push_c && !out_pop_c)      out_cnt_d = out_cnt_q + CW'(1);
        else if (!out_push_c && out_pop_c) out_cnt_d = out_cnt_q - CW'(1);

        // A drop on the same edge as a status read keeps the flag set.
        drop_d = drop_q;
        if (drop_c)                         drop_d = 1'b1;
        else if (rd_c && addr == 2'b11)     drop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_wp_q   <= '0;
            in_rp_q   <= '0;
            in_cnt_q  <= '0;
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            in_wp_q   <= in_wp_d;
            in_rp_q   <= in_rp_d;
            in_cnt_q  <= in_cnt_d;
            out_wp_q  <= out_wp_d;
            out_rp_q  <= out_rp_d;
            out_cnt_q <= out_cnt_d;
            drop_q    <= drop_d;
        end
    end

    // Packet storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && in_push_c)  in_mem_q[in_wp_q]   <= net_di;
        if (!reset && out_push_c) out_mem_q[out_wp_q] <= d_in;
    end

endmodule

// File: tb/tb_nic_buffered.sv
// Directed bench for nic_buffered (DATA_W=64, DEPTH=4) with hand-computed expectations.
module tb_nic_buffered;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in, d_out, net_di, net_do;
    logic        nicEn, nicEnWr, net_si, net_ri, net_so, net_ro, net_polarity;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    nic_buffered #(.DATA_W(64), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        nicEn = 0; nicEnWr = 0; addr = 2'b00; d_in = '0; net_si = 0; net_di = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1; nicEnWr = 0; addr = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1; nicEnWr = 1; addr = a; d_in = d;
    endtask

    initial begin
        idle();
        reset = 1; net_ro = 0; net_polarity = 0;
        tick(); tick();
        reset = 0;
        #1;
        check("rst_net_ri", 64'(net_ri), 64'd1);
        check("rst_net_so", 64'(net_so), 64'd0);
        check("rst_net_do", net_do, 64'd0);
        check("rst_d_out", d_out, 64'd0);

        // Fill input FIFO; fifth packet must be refused.
        for (int i = 1; i <= 5; i++) begin
            net_si = 1; net_di = 64'(i);
            tick();
            check($sformatf("fill_ri_%0d", i), 64'(net_ri), (i < 4) ? 64'd1 : 64'd0);
        end
        idle();
        rd(2'b01);
        check("fill_status", d_out, 64'h0000_0004_0000_0001);
        tick();
        for (int i = 1; i <= 4; i++) begin
            rd(2'b00);
            check($sformatf("fill_rd_%0d", i), d_out, 64'(i));
            tick();
        end
        rd(2'b00);
        check("fill_rd_empty", d_out, 64'd0);
        tick();
        rd(2'b01);
        check("fill_status_empty", d_out, 64'd0);
        tick();
        idle();

        // Polarity gating on output channel.
        net_ro = 1; net_polarity = 0;
        wr(2'b10, 64'h8000_0000_0000_00AA);
        tick();
        idle();
        #1;
        check("pol_so_blocked", 64'(net_so), 64'd0);
        check("pol_do_head", net_do, 64'h8000_0000_0000_00AA);
        tick();
        check("pol_so_still_blocked", 64'(net_so), 64'd0);
        net_polarity = 1;
        #1;
        check("pol_so_open", 64'(net_so), 64'd1);
        check("pol_do", net_do, 64'h8000_0000_0000_00AA);
        tick();
        check("pol_so_once", 64'(net_so), 64'd0);
        check("pol_do_empty", net_do, 64'd0);
        rd(2'b11);
        check("pol_out_status", d_out, 64'd0);
        tick();
        idle();
        net_polarity = 0;

        // Output overflow and sticky drop flag.
        net_ro = 0;
        for (int i = 0; i < 5; i++) begin
            wr(2'b10, 64'h10 + 64'(i));
            tick();
        end
        idle();
        rd(2'b11);
        check("ovf_status_drop", d_out, 64'h0000_0004_0000_0003);
        tick();
        rd(2'b11);
        check("ovf_status_clr", d_out, 64'h0000_0004_0000_0001);
        tick();
        idle();
        net_ro = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("ovf_drain_so_%0d", i), 64'(net_so), 64'd1);
            check($sformatf("ovf_drain_do_%0d", i), net_do, 64'h10 + 64'(i));
            tick();
        end
        check("ovf_drained", 64'(net_so), 64'd0);
        net_ro = 0;

        // Simultaneous push and pop on the input channel.
        for (int i = 1; i <= 2; i++) begin
            net_si = 1; net_di = 64'h20 + 64'(i);
            tick();
        end
        net_si = 1; net_di = 64'h23;
        rd(2'b00);
        check("sim_pop_a", d_out, 64'h21);
        tick();
        idle();
        rd(2'b01);
        check("sim_count2", d_out, 64'h0000_0002_0000_0001);
        tick();
        idle();
        for (int i = 4; i <= 5; i++) begin
            net_si = 1; net_di = 64'h20 + 64'(i);
            tick();
        end
        idle();
        #1;
        check("sim_full_ri", 64'(net_ri), 64'd0);
        net_si = 1; net_di = 64'h26;
        rd(2'b00);
        check("sim_pop_full", d_out, 64'h22);
        tick();
        idle();
        rd(2'b01);
        check("sim_count3", d_out, 64'h0000_0003_0000_0001);
        tick();
        for (int i = 3; i <= 5; i++) begin
            rd(2'b00);
            check($sformatf("sim_order_%0d", i), d_out, 64'h20 + 64'(i));
            tick();
        end
        rd(2'b01);
        check("sim_empty", d_out, 64'd0);
        tick();
        idle();

        // Reset mid-stream with traffic on the reset edge.
        for (int i = 0; i < 3; i++) begin
            net_si = 1; net_di = 64'h30 + 64'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            wr(2'b10, 64'h40 + 64'(i));
            tick();
        end
        idle();
        reset = 1; net_si = 1; net_di = 64'h50; wr(2'b10, 64'h51);
        tick();
        reset = 0;
        idle();
        net_ro = 1; net_polarity = 0;
        #1;
        check("mid_rst_so", 64'(net_so), 64'd0);
        check("mid_rst_ri", 64'(net_ri), 64'd1);
        check("mid_rst_do", net_do, 64'd0);
        rd(2'b01);
        check("mid_rst_in_status", d_out, 64'd0);
        rd(2'b11);
        check("mid_rst_out_status", d_out, 64'd0);
        tick();
        idle();

        // Wrap-around: 12 packets through the input channel, push and pop interleaved.
        exp_q.delete();
        for (int k = 0; k < 14; k++) begin
            if (k < 12) begin net_si = 1; net_di = 64'h100 + 64'(k); end
            else net_si = 0;
            if (k >= 2) begin
                rd(2'b00);
                check($sformatf("wrap_in_%0d", k), d_out, exp_q.pop_front());
            end
            if (k < 12) exp_q.push_back(64'h100 + 64'(k));
            tick();
            idle();
        end
        rd(2'b01);
        check("wrap_in_empty", d_out, 64'd0);
        tick();
        idle();

        // Wrap-around: 12 packets through the output channel, write and send overlapped.
        exp_q.delete();
        net_ro = 1; net_polarity = 0;
        for (int k = 0; k < 13; k++) begin
            if (k < 12) wr(2'b10, 64'h200 + 64'(k));
            else idle();
            #1;
            if (exp_q.size() > 0) begin
                check($sformatf("wrap_out_so_%0d", k), 64'(net_so), 64'd1);
                check($sformatf("wrap_out_do_%0d", k), net_do, exp_q.pop_front());
            end
            if (k < 12) exp_q.push_back(64'h200 + 64'(k));
            tick();
        end
        idle();
        #1;
        check("wrap_out_done", 64'(net_so), 64'd0);
        rd(2'b11);
        check("wrap_out_status", d_out, 64'd0);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
